// File: rtl/muldiv_ctrl.sv
// Iterative RV32 M-extension unit: shift-add multiply and restoring divide.
// Divide-by-zero and signed overflow skip the iteration loop.
module muldiv_ctrl #(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] op_a,
  input  logic [D_WIDTH-1:0] op_b,
  input  logic               flush,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] result
);

  localparam int unsigned W = D_WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [2:0]       fn_q, fn_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             fast_q, fast_d;
  logic             busy_q, done_q;
  logic [W-1:0]     result_q;

  // Operand decode for the request presented this cycle.
  logic           is_mul_in, a_sgn_in, b_sgn_in, a_neg, b_neg, neg_in;
  logic           div_zero, div_ovf;
  logic [W-1:0]   a_mag, b_mag, fast_res;

  always_comb begin
    is_mul_in = ~funct3[2];
    a_sgn_in  = is_mul_in ? (funct3 != 3'd3) : ~funct3[0];
    b_sgn_in  = is_mul_in ? ~funct3[1] : ~funct3[0];
    a_neg     = a_sgn_in & op_a[W-1];
    b_neg     = b_sgn_in & op_b[W-1];
    a_mag     = a_neg ? -op_a : op_a;
    b_mag     = b_neg ? -op_b : op_b;
    // Remainder follows the dividend; products and quotients follow the sign product.
    neg_in    = (is_mul_in || !funct3[1]) ? (a_neg ^ b_neg) : a_neg;
    div_zero  = !is_mul_in && (op_b == '0);
    div_ovf   = !is_mul_in && !funct3[0] && (op_a == {1'b1, {(W-1){1'b0}}}) && (&op_b);
    if (div_zero) begin
      fast_res = funct3[1] ? op_a : '1;
    end else begin
      fast_res = funct3[1] ? '0 : op_a;
    end
  end

  // One iteration of each algorithm; acc holds {high/remainder, low/quotient}.
  logic [W:0]     mul_sum, div_trial, div_diff;
  logic [2*W-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_trial = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = div_trial - {1'b0, opnd_q};
    if (!div_diff[W]) begin
      div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {div_trial[W-1:0], acc_q[W-2:0], 1'b0};
    end
  end

  // Final sign fix-up and field selection.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fin_res;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    if (fast_q) begin
      fin_res = acc_q[W-1:0];
    end else if (!fn_q[2]) begin
      fin_res = (fn_q == 3'd0) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    end else begin
      fin_res = fn_q[1] ? rem_fix : quo_fix;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fn_d    = fn_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    fast_d  = fast_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          fn_d   = funct3;
          neg_d  = neg_in;
          opnd_d = b_mag;
          cnt_d  = '0;
          if (div_zero || div_ovf) begin
            fast_d  = 1'b1;
            acc_d   = {{W{1'b0}}, fast_res};
            state_d = StFin;
          end else begin
            fast_d  = 1'b0;
            acc_d   = {{W{1'b0}}, a_mag};
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d = fn_q[2] ? div_next : mul_next;
          if (cnt_q == 6'd31) begin
            state_d = StFin;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      fn_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fn_q    <= fn_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      fast_q  <= fast_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_q == StFin) && !flush;
      if ((state_q == StFin) && !flush) begin
        result_q <= fin_res;
      end
    end
  end

  assign stall  = (state_q == StRun) || ((state_q == StIdle) && start && !flush);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
